// File: rtl/switch_arbiter.sv
// Output-side round-robin arbiter and 4:1 crossbar for the 4-port switch.
// Each output lane keeps its own fairness pointer and a registered word with ready/valid.
module switch_arbiter #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS*NPORTS-1:0]  dst_flat,
  input  logic [NPORTS*DATA_W-1:0]  data_flat,
  input  logic [NPORTS-1:0]         out_ready,
  output logic [NPORTS-1:0]         grant,
  output logic [NPORTS-1:0]         out_valid,
  output logic [NPORTS*DATA_W-1:0]  out_data,
  output logic [NPORTS-1:0]         dst_err,
  output logic [NPORTS*CNT_W-1:0]   pkt_cnt
);

  localparam int unsigned PTR_W = $clog2(NPORTS);

  logic [NPORTS-1:0][NPORTS-1:0] dst;
  logic [NPORTS-1:0][DATA_W-1:0] din;
  logic [NPORTS-1:0]             dst_ok;
  logic [NPORTS-1:0][NPORTS-1:0] cand;      // cand[i][j]: input i eligible for lane j
  logic [NPORTS-1:0]             lane_free;
  logic [NPORTS-1:0]             lane_hit;
  logic [NPORTS-1:0][PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]              idx;
  logic [NPORTS-1:0]             grant_raw;

  logic [NPORTS-1:0][PTR_W-1:0]  ptr_q;
  logic [NPORTS-1:0]             valid_q;
  logic [NPORTS-1:0][DATA_W-1:0] data_q;
  logic [NPORTS-1:0][CNT_W-1:0]  cnt_q;
  logic [NPORTS-1:0]             err_q;

  assign dst = dst_flat;
  assign din = data_flat;

  // Candidate matrix; malformed destinations never compete for any lane.
  always_comb begin
    dst_ok = '0;
    cand   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dst_ok[i] = $onehot(dst[i]);
      for (int j = 0; j < NPORTS; j++) begin
        cand[i][j] = req[i] && dst[i][j] && dst_ok[i];
      end
    end
  end

  assign lane_free = ~valid_q | out_ready;

  // Per-lane round-robin search starting at the lane pointer.
  always_comb begin
    lane_hit = '0;
    win_idx  = '0;
    idx      = '0;
    for (int j = 0; j < NPORTS; j++) begin
      for (int k = 0; k < NPORTS; k++) begin
        idx = ptr_q[j] + PTR_W'(k);
        if (lane_free[j] && !lane_hit[j] && cand[idx][j]) begin
          lane_hit[j] = 1'b1;
          win_idx[j]  = idx;
        end
      end
    end
  end

  always_comb begin
    grant_raw = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (lane_hit[j]) begin
        grant_raw[win_idx[j]] = 1'b1;
      end
    end
  end

  // Grant pops the port FIFO directly, so it must be quiet while reset is held.
  assign grant = grant_raw & {NPORTS{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      err_q <= req & ~dst_ok;
      for (int j = 0; j < NPORTS; j++) begin
        if (lane_hit[j]) begin
          data_q[j]  <= din[win_idx[j]];
          valid_q[j] <= 1'b1;
          ptr_q[j]   <= win_idx[j] + PTR_W'(1);
        end else if (valid_q[j] && out_ready[j]) begin
          valid_q[j] <= 1'b0;
        end
        if (valid_q[j] && out_ready[j]) begin
          cnt_q[j] <= cnt_q[j] + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign dst_err   = err_q;
  assign pkt_cnt   = cnt_q;

endmodule
